// File: rtl/soc_periph_demux_pkg.sv
// SoC address map: slave index enum, region base/length constants and lookup helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package soc_periph_demux_pkg;

   localparam int NrTargets = 10;
   localparam int IdxWidth  = $clog2(NrTargets + 1);

   // Slave index order; index NrTargets is reserved for the internal error responder.
   typedef enum logic [3:0] {
      SlvDram  = 4'd0,
      SlvGpio  = 4'd1,
      SlvEth   = 4'd2,
      SlvSpi   = 4'd3,
      SlvTimer = 4'd4,
      SlvUart  = 4'd5,
      SlvPlic  = 4'd6,
      SlvClint = 4'd7,
      SlvRom   = 4'd8,
      SlvDebug = 4'd9
   } slave_e;

   localparam logic [63:0] DebugBase  = 64'h0000_0000;  localparam logic [63:0] DebugLength = 64'h0000_1000;
   localparam logic [63:0] RomBase    = 64'h0001_0000;  localparam logic [63:0] RomLength   = 64'h0001_0000;
   localparam logic [63:0] ClintBase  = 64'h0200_0000;  localparam logic [63:0] ClintLength = 64'h000C_0000;
   localparam logic [63:0] PlicBase   = 64'h0C00_0000;  localparam logic [63:0] PlicLength  = 64'h03FF_FFFF;
   localparam logic [63:0] UartBase   = 64'h1000_0000;  localparam logic [63:0] UartLength  = 64'h0000_1000;
   localparam logic [63:0] TimerBase  = 64'h1800_0000;  localparam logic [63:0] TimerLength = 64'h0000_1000;
   localparam logic [63:0] SpiBase    = 64'h2000_0000;  localparam logic [63:0] SpiLength   = 64'h0080_0000;
   localparam logic [63:0] EthBase    = 64'h3000_0000;  localparam logic [63:0] EthLength   = 64'h0001_0000;
   localparam logic [63:0] GpioBase   = 64'h4000_0000;  localparam logic [63:0] GpioLength  = 64'h0000_1000;
   localparam logic [63:0] DramBase   = 64'h8000_0000;  localparam logic [63:0] DramLength  = 64'h4000_0000;

   function automatic logic [63:0] region_base(input int idx);
      case (idx)
         0:       return DramBase;
         1:       return GpioBase;
         2:       return EthBase;
         3:       return SpiBase;
         4:       return TimerBase;
         5:       return UartBase;
         6:       return PlicBase;
         7:       return ClintBase;
         8:       return RomBase;
         9:       return DebugBase;
         default: return 64'h0;
      endcase
   endfunction

   // Zero length for unknown indices makes them impossible to hit.
   function automatic logic [63:0] region_length(input int idx);
      case (idx)
         0:       return DramLength;
         1:       return GpioLength;
         2:       return EthLength;
         3:       return SpiLength;
         4:       return TimerLength;
         5:       return UartLength;
         6:       return PlicLength;
         7:       return ClintLength;
         8:       return RomLength;
         9:       return DebugLength;
         default: return 64'h0;
      endcase
   endfunction

endpackage

// File: rtl/soc_addr_decode.sv
// Address to slave-index decoder over the SoC map; miss yields idx = NrTargets, hit = 0.
// Latency: purely combinational.
// Backpressure: none.
// Ports: addr_i byte address in; idx_o decoded slave index; hit_o set when a region matched.
module soc_addr_decode
   import soc_periph_demux_pkg::*;
#(
   parameter int AddrWidth = 64
) (
   input  logic [AddrWidth-1:0] addr_i,
   output logic [IdxWidth-1:0]  idx_o,
   output logic                 hit_o
);

   logic [63:0] addr64;
   assign addr64 = 64'(addr_i);

   // Regions do not overlap, so at most one iteration can match.
   always_comb begin
      idx_o = IdxWidth'(NrTargets);
      hit_o = 1'b0;
      for (int i = 0; i < NrTargets; i++) begin
         if ((addr64 >= region_base(i)) && (addr64 < region_base(i) + region_length(i))) begin
            idx_o = IdxWidth'(i);
            hit_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/soc_periph_demux.sv
// In-order single-master demux from the CPU peripheral port to the SoC map targets, with inline decode-error responder.
// Latency: zero added request latency; responses pass through combinationally; decode errors answer exactly 1 cycle after accept.
// Backpressure: req_ready_o follows the selected slave's ready; stalls on target switch until drained or at MaxOutstanding.
// Ports: req_* master request, rsp_* master response, slv_req_* broadcast payload with per-target valid/ready, slv_rsp_* per-target responses.
module soc_periph_demux #(
   parameter int NrTargets      = 10,
   parameter int MaxOutstanding = 4,
   parameter int AddrWidth      = 64,
   parameter int DataWidth      = 64
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                req_valid_i,
   output logic                                req_ready_o,
   input  logic [AddrWidth-1:0]                req_addr_i,
   input  logic                                req_we_i,
   input  logic [DataWidth-1:0]                req_wdata_i,
   input  logic [DataWidth/8-1:0]              req_be_i,
   output logic                                rsp_valid_o,
   output logic [DataWidth-1:0]                rsp_rdata_o,
   output logic                                rsp_err_o,
   output logic [NrTargets-1:0]                slv_req_valid_o,
   input  logic [NrTargets-1:0]                slv_req_ready_i,
   output logic [AddrWidth-1:0]                slv_req_addr_o,
   output logic                                slv_req_we_o,
   output logic [DataWidth-1:0]                slv_req_wdata_o,
   output logic [DataWidth/8-1:0]              slv_req_be_o,
   input  logic [NrTargets-1:0]                slv_rsp_valid_i,
   input  logic [NrTargets-1:0][DataWidth-1:0] slv_rsp_rdata_i,
   input  logic [NrTargets-1:0]                slv_rsp_err_i
);

   import soc_periph_demux_pkg::*;

   localparam int IdxW = $clog2(NrTargets + 1);
   localparam int CntW = $clog2(MaxOutstanding + 1);
   localparam logic [IdxW-1:0] ErrIdx = IdxW'(NrTargets);

   logic [IdxW-1:0]      sel_q;
   logic [CntW-1:0]      cnt_q;
   logic                 err_pending_q;

   logic [IdxW-1:0]      dec_idx;
   logic                 dec_hit;
   logic                 issue_ok;
   logic                 issue_hs;
   logic                 sel_rsp_vld;
   logic                 sel_rsp_err;
   logic [DataWidth-1:0] sel_rsp_dat;
   logic [NrTargets-1:0] sel_mask;

   soc_addr_decode #(
      .AddrWidth (AddrWidth)
   ) u_decode (
      .addr_i (req_addr_i),
      .idx_o  (dec_idx),
      .hit_o  (dec_hit)
   );

   // Payload is broadcast; only the per-target valid qualifies it.
   assign slv_req_addr_o  = req_addr_i;
   assign slv_req_we_o    = req_we_i;
   assign slv_req_wdata_o = req_wdata_i;
   assign slv_req_be_o    = req_be_i;

   // Keeping all in-flight requests on one target is what guarantees in-order responses.
   assign issue_ok = (cnt_q == '0) ||
                     ((dec_idx == sel_q) && (cnt_q < CntW'(MaxOutstanding)));

   // Gated by rst_ni so nothing is offered to the master or slaves while reset is held.
   always_comb begin
      slv_req_valid_o = '0;
      req_ready_o     = 1'b0;
      if (rst_ni && issue_ok) begin
         if (dec_hit) begin
            for (int t = 0; t < NrTargets; t++) begin
               if (dec_idx == IdxW'(t)) begin
                  slv_req_valid_o[t] = req_valid_i;
                  req_ready_o        = slv_req_ready_i[t];
               end
            end
         end else begin
            // Error responder holds a single request at a time.
            req_ready_o = ~err_pending_q;
         end
      end
   end

   assign issue_hs = req_valid_i & req_ready_o;

   always_comb begin
      sel_rsp_vld = 1'b0;
      sel_rsp_err = 1'b0;
      sel_rsp_dat = '0;
      sel_mask    = '0;
      if (sel_q == ErrIdx) begin
         sel_rsp_vld = err_pending_q;
         sel_rsp_err = 1'b1;
      end else begin
         for (int t = 0; t < NrTargets; t++) begin
            if (sel_q == IdxW'(t)) begin
               sel_mask[t] = 1'b1;
               sel_rsp_vld = slv_rsp_valid_i[t];
               sel_rsp_err = slv_rsp_err_i[t];
               sel_rsp_dat = slv_rsp_rdata_i[t];
            end
         end
      end
   end

   // Nothing is in flight at cnt_q == 0, so stray responses (e.g. after reset) are dropped.
   assign rsp_valid_o = sel_rsp_vld & (cnt_q != '0);
   assign rsp_err_o   = rsp_valid_o & sel_rsp_err;
   assign rsp_rdata_o = rsp_valid_o ? sel_rsp_dat : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sel_q         <= '0;
         cnt_q         <= '0;
         err_pending_q <= 1'b0;
      end else begin
         if (issue_hs) begin
            sel_q <= dec_idx;
         end
         if (issue_hs && !rsp_valid_o) begin
            cnt_q <= cnt_q + CntW'(1);
         end else if (!issue_hs && rsp_valid_o) begin
            cnt_q <= cnt_q - CntW'(1);
         end
         if (issue_hs && !dec_hit) begin
            err_pending_q <= 1'b1;
         end else if (err_pending_q) begin
            err_pending_q <= 1'b0;
         end
      end
   end

   a_no_foreign_rsp : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (cnt_q != '0) |-> ((slv_rsp_valid_i & ~sel_mask) == '0));

   a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      rsp_valid_o |-> (cnt_q != '0));

endmodule

// File: tb/tb_soc_periph_demux.sv
// Directed self-checking bench for soc_periph_demux.
// Latency: inputs driven on negedge, outputs checked 1 time unit later.
// Backpressure: slave readies held high; stalls come from the ordering rules.
module tb_soc_periph_demux;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              req_valid_i;
   logic              req_ready_o;
   logic [63:0]       req_addr_i;
   logic              req_we_i;
   logic [63:0]       req_wdata_i;
   logic [7:0]        req_be_i;
   logic              rsp_valid_o;
   logic [63:0]       rsp_rdata_o;
   logic              rsp_err_o;
   logic [9:0]        slv_req_valid_o;
   logic [9:0]        slv_req_ready_i;
   logic [63:0]       slv_req_addr_o;
   logic              slv_req_we_o;
   logic [63:0]       slv_req_wdata_o;
   logic [7:0]        slv_req_be_o;
   logic [9:0]        slv_rsp_valid_i;
   logic [9:0][63:0]  slv_rsp_rdata_i;
   logic [9:0]        slv_rsp_err_i;

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   soc_periph_demux dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_addr_i      (req_addr_i),
      .req_we_i        (req_we_i),
      .req_wdata_i     (req_wdata_i),
      .req_be_i        (req_be_i),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_rdata_o     (rsp_rdata_o),
      .rsp_err_o       (rsp_err_o),
      .slv_req_valid_o (slv_req_valid_o),
      .slv_req_ready_i (slv_req_ready_i),
      .slv_req_addr_o  (slv_req_addr_o),
      .slv_req_we_o    (slv_req_we_o),
      .slv_req_wdata_o (slv_req_wdata_o),
      .slv_req_be_o    (slv_req_be_o),
      .slv_rsp_valid_i (slv_rsp_valid_i),
      .slv_rsp_rdata_i (slv_rsp_rdata_i),
      .slv_rsp_err_i   (slv_rsp_err_i)
   );

   task automatic test_reset();
      rst_ni = 1'b1;
      #2 rst_ni = 1'b0;
      req_valid_i = 1'b1;
      req_addr_i  = 64'h5000_0000;
      #1;
      checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready_o); end
      checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid_o); end
      checks++; if (rsp_rdata_o !== 64'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata_o); end
      checks++; if (rsp_err_o !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err_o); end
      checks++; if (slv_req_valid_o !== 10'h000) begin failures++; $display("FAIL reset_slv_valid got=%h exp=000", slv_req_valid_o); end
      repeat (2) @(negedge clk_i);
      rst_ni      = 1'b1;
      req_valid_i = 1'b0;
   endtask

   task automatic test_uart_read();
      @(negedge clk_i);
      req_valid_i = 1'b1; req_addr_i = 64'h1000_0000; req_we_i = 1'b0; req_be_i = 8'hFF;
      #1;
      checks++; if (slv_req_valid_o !== 10'h020) begin failures++; $display("FAIL uart_slv_valid got=%h exp=020", slv_req_valid_o); end
      checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL uart_ready got=%b exp=1", req_ready_o); end
      checks++; if (slv_req_addr_o !== 64'h1000_0000) begin failures++; $display("FAIL uart_addr got=%h exp=10000000", slv_req_addr_o); end
      @(negedge clk_i);
      req_valid_i = 1'b0;
      #1;
      checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL uart_early_rsp got=%b exp=0", rsp_valid_o); end
      @(negedge clk_i);
      slv_rsp_valid_i[5] = 1'b1; slv_rsp_rdata_i[5] = 64'hDEAD;
      #1;
      checks++; if (rsp_valid_o !== 1'b1) begin failures++; $display("FAIL uart_rsp_valid got=%b exp=1", rsp_valid_o); end
      checks++; if (rsp_rdata_o !== 64'hDEAD) begin failures++; $display("FAIL uart_rsp_rdata got=%h exp=dead", rsp_rdata_o); end
      checks++; if (rsp_err_o !== 1'b0) begin failures++; $display("FAIL uart_rsp_err got=%b exp=0", rsp_err_o); end
      @(negedge clk_i);
      slv_rsp_valid_i[5] = 1'b0;
      // A different target is accepted at once only if the count drained to zero.
      req_valid_i = 1'b1; req_addr_i = 64'h4000_0000;
      #1;
      checks++; if (slv_req_valid_o !== 10'h002 || req_ready_o !== 1'b1) begin failures++; $display("FAIL uart_drained got=%h/%b exp=002/1", slv_req_valid_o, req_ready_o); end
      req_valid_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         req_valid_i = 1'b1; req_we_i = 1'b1;
         req_addr_i  = 64'h8000_0000 + 64'(i * 8);
         req_wdata_i = 64'h1111_0000 + 64'(i);
         #1;
         checks++; if (req_ready_o !== 1'b1 || slv_req_valid_o !== 10'h001) begin failures++; $display("FAIL b2b_accept%0d got=%b/%h exp=1/001", i, req_ready_o, slv_req_valid_o); end
         checks++; if (slv_req_wdata_o !== 64'h1111_0000 + 64'(i)) begin failures++; $display("FAIL b2b_wdata%0d got=%h", i, slv_req_wdata_o); end
      end
      @(negedge clk_i);
      req_addr_i = 64'h8000_0020;
      #1;
      checks++; if (req_ready_o !== 1'b0 || slv_req_valid_o !== 10'h000) begin failures++; $display("FAIL b2b_fifth_stall got=%b/%h exp=0/000", req_ready_o, slv_req_valid_o); end
      @(negedge clk_i);
      slv_rsp_valid_i[0] = 1'b1;
      #1;
      checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL b2b_stall_rsp_cycle got=%b exp=0", req_ready_o); end
      checks++; if (rsp_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_first_rsp got=%b exp=1", rsp_valid_o); end
      @(negedge clk_i);
      slv_rsp_valid_i[0] = 1'b0;
      #1;
      checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_fifth_accept got=%b exp=1", req_ready_o); end
      @(negedge clk_i);
      req_valid_i = 1'b0; req_we_i = 1'b0;
      slv_rsp_valid_i[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (rsp_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_drain%0d got=%b exp=1", k, rsp_valid_o); end
         @(negedge clk_i);
      end
      #1;
      checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL b2b_extra_rsp got=%b exp=0", rsp_valid_o); end
      slv_rsp_valid_i[0] = 1'b0;
   endtask

   task automatic test_order_stall();
      @(negedge clk_i);
      req_valid_i = 1'b1; req_addr_i = 64'h8000_0100;
      #1;
      checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL order_dram_accept got=%b exp=1", req_ready_o); end
      @(negedge clk_i);
      req_addr_i = 64'h0200_0000;
      #1;
      checks++; if (req_ready_o !== 1'b0 || slv_req_valid_o !== 10'h000) begin failures++; $display("FAIL order_clint_stall got=%b/%h exp=0/000", req_ready_o, slv_req_valid_o); end
      @(negedge clk_i);
      slv_rsp_valid_i[0] = 1'b1; slv_rsp_rdata_i[0] = 64'h1234;
      #1;
      checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 64'h1234) begin failures++; $display("FAIL order_dram_rsp got=%b/%h exp=1/1234", rsp_valid_o, rsp_rdata_o); end
      checks++; if (slv_req_valid_o !== 10'h000) begin failures++; $display("FAIL order_still_stalled got=%h exp=000", slv_req_valid_o); end
      @(negedge clk_i);
      slv_rsp_valid_i[0] = 1'b0;
      #1;
      checks++; if (slv_req_valid_o !== 10'h080 || req_ready_o !== 1'b1) begin failures++; $display("FAIL order_clint_issue got=%h/%b exp=080/1", slv_req_valid_o, req_ready_o); end
      @(negedge clk_i);
      req_valid_i = 1'b0;
      slv_rsp_valid_i[7] = 1'b1; slv_rsp_err_i[7] = 1'b1; slv_rsp_rdata_i[7] = 64'hBEEF;
      #1;
      checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1) begin failures++; $display("FAIL order_slave_err got=%b/%b exp=1/1", rsp_valid_o, rsp_err_o); end
      @(negedge clk_i);
      slv_rsp_valid_i[7] = 1'b0; slv_rsp_err_i[7] = 1'b0;
   endtask

   task automatic test_unmapped();
      @(negedge clk_i);
      slv_rsp_rdata_i[9] = 64'hFFFF_FFFF;
      req_valid_i = 1'b1; req_addr_i = 64'h5000_0000;
      #1;
      checks++; if (req_ready_o !== 1'b1 || slv_req_valid_o !== 10'h000) begin failures++; $display("FAIL err_accept got=%b/%h exp=1/000", req_ready_o, slv_req_valid_o); end
      checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL err_zero_latency got=%b exp=0", rsp_valid_o); end
      @(negedge clk_i);
      req_valid_i = 1'b0;
      #1;
      checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 64'h0) begin failures++; $display("FAIL err_rsp got=%b/%b/%h exp=1/1/0", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
      @(negedge clk_i);
      #1;
      checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL err_single_rsp got=%b exp=0", rsp_valid_o); end
   endtask

   task automatic test_boundary();
      logic [63:0] addrs [10];
      logic [9:0]  masks [10];
      addrs = '{64'h0000_0FFF, 64'h0000_1000, 64'h0001_0FFF, 64'h0FFF_FFFE, 64'h0FFF_FFFF,
                64'h1000_1000, 64'hBFFF_FFF8, 64'hC000_0000, 64'h1800_0FFF, 64'h2080_0000};
      masks = '{10'h200, 10'h000, 10'h100, 10'h040, 10'h000,
                10'h000, 10'h001, 10'h000, 10'h010, 10'h000};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         req_valid_i = 1'b1; req_addr_i = addrs[i];
         #1;
         checks++; if (slv_req_valid_o !== masks[i] || req_ready_o !== 1'b1) begin failures++; $display("FAIL boundary_%h got=%h/%b exp=%h/1", addrs[i], slv_req_valid_o, req_ready_o, masks[i]); end
         req_valid_i = 1'b0;
      end
   endtask

   task automatic test_reset_midop();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         req_valid_i = 1'b1; req_addr_i = 64'h8000_0040 + 64'(i * 8);
      end
      @(negedge clk_i);
      rst_ni = 1'b0;
      slv_rsp_valid_i[0] = 1'b1;
      #1;
      checks++; if (slv_req_valid_o !== 10'h000 || req_ready_o !== 1'b0) begin failures++; $display("FAIL midrst_req got=%h/%b exp=000/0", slv_req_valid_o, req_ready_o); end
      checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_rsp got=%b exp=0", rsp_valid_o); end
      @(negedge clk_i);
      rst_ni = 1'b1; req_valid_i = 1'b0;
      #1;
      checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_late_rsp got=%b exp=0", rsp_valid_o); end
      @(negedge clk_i);
      slv_rsp_valid_i[0] = 1'b0;
      req_valid_i = 1'b1; req_addr_i = 64'h4000_0000;
      #1;
      checks++; if (slv_req_valid_o !== 10'h002 || req_ready_o !== 1'b1) begin failures++; $display("FAIL midrst_gpio got=%h/%b exp=002/1", slv_req_valid_o, req_ready_o); end
      @(negedge clk_i);
      req_valid_i = 1'b0;
      slv_rsp_valid_i[1] = 1'b1; slv_rsp_rdata_i[1] = 64'h55;
      #1;
      checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 64'h55) begin failures++; $display("FAIL midrst_gpio_rsp got=%b/%h exp=1/55", rsp_valid_o, rsp_rdata_o); end
      @(negedge clk_i);
      slv_rsp_valid_i[1] = 1'b0;
   endtask

   initial begin
      rst_ni          = 1'b1;
      req_valid_i     = 1'b0;
      req_addr_i      = '0;
      req_we_i        = 1'b0;
      req_wdata_i     = '0;
      req_be_i        = '0;
      slv_req_ready_i = '1;
      slv_rsp_valid_i = '0;
      slv_rsp_rdata_i = '0;
      slv_rsp_err_i   = '0;

      test_reset();
      test_uart_read();
      test_back_to_back();
      test_order_stall();
      test_unmapped();
      test_boundary();
      test_reset_midop();

      repeat (2) @(negedge clk_i);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
